comp_weight_loader: RTL and testbench
=====================================

// Module: comp_weight_loader
// PURPOSE
//  Transmit side of the compensation-weight preload path.
//  - Reads one tile of 3-bit compensation weights from the compensation memory, one row per cycle.
//  - Shifts the rows into the top of the CPE columns as a contiguous burst with a valid strobe.
//  - The CPE chain shifts weights down on every valid beat. Rows are therefore sent last-row-first,
//    so that after ROWS beats CPE row r holds weight row r.
// PARAMETERS
//  ROWS    8   CPE rows per column = beats per tile load
//  COLS    8   CPE columns; memory word and cw_out are 3*COLS bits
//  ADDR_W  10  compensation memory address width
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         synchronous reset, active-high
//  start        in   1         one-cycle request to load a tile; sampled only in IDLE
//  abort        in   1         cancel an in-progress load
//  tile_base    in   ADDR_W    memory address of weight row 0 of the tile; sampled with start
//  mem_rd_en    out  1         memory read enable
//  mem_rd_addr  out  ADDR_W    memory read address
//  mem_rd_data  in   3*COLS    read data, valid exactly 1 cycle after mem_rd_en
//  cw_out       out  3*COLS    weights to CPE row 0; column c = cw_out[3c+2:3c]
//  cw_valid     out  1         weight-valid to the CPE columns (broadcast down each column)
//  busy         out  1         a load is in progress
//  done         out  1         one-cycle pulse when a full tile has been shifted in
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-load drops the load with no done pulse.
//  States:
//  - IDLE: start=1 latches tile_base and goes to FETCH.
//  - FETCH: issues ROWS reads, one per cycle, at tile_base+ROWS-1 down to tile_base.
//    After the last read, goes to DRAIN.
//  - DRAIN: the last beat goes out; then go to DONE.
//  - DONE: done=1 for one cycle; then IDLE.
//  Timing, with start sampled at edge T:
//  - mem_rd_en=1 in cycles T+1..T+ROWS.
//  - cw_out and cw_valid are registered from mem_rd_data. The first beat is in cycle T+3.
//  - Beats are ROWS consecutive cycles with no gaps; cw_valid=1 in T+3..T+ROWS+2.
//  - done in cycle T+ROWS+3.
//  - busy=1 from T+1 through the done cycle, inclusive.
//  - A new start can be accepted in the cycle after done, i.e. T+ROWS+4.
//  cw_out holds its last value while cw_valid=0. CPEs ignore the data when valid is low.
//  Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. No range check is made.
//  A start while busy is ignored. It is not queued.
//  abort=1 in any non-IDLE state:
//  - next cycle: state IDLE, mem_rd_en=0, cw_valid=0, busy=0, no done;
//  - read data still in flight is discarded.
//  abort and start in the same cycle while IDLE: abort wins and start is ignored.
//  The CPE columns hold a partial, shifted tile after an abort; the controller must reload.
//  The beat counter counts down from ROWS-1. Its width is $clog2(ROWS), minimum 1.
// TESTING (ROWS=4, COLS=2, ADDR_W=10)
//  1. Memory rows 0x100..0x103 = {c1,c0} of {1,0},{3,2},{5,4},{7,6}; start with tile_base=0x100 ->
//     reads 0x103,0x102,0x101,0x100 in T+1..T+4; cw_out 6'o76,6'o54,6'o32,6'o10 in T+3..T+6;
//     done at T+7.
//  2. Bench model of a 4-deep CPE shift chain driven by cw_out/cw_valid -> after done, rows 0..3
//     hold 6'o10,6'o32,6'o54,6'o76.
//  3. Second start pulse at T+2 while busy -> ignored: exactly 4 beats and a single done.
//     Start at T+8 -> accepted; reads begin T+9.
//  4. abort at T+4 -> cycle T+5: mem_rd_en=0, cw_valid=0, busy=0; done never asserts;
//     the next start works normally.
//  5. tile_base=0x3FE -> read addresses 0x001,0x000,0x3FF,0x3FE, showing the address wrap.
//  6. rst=1 at T+5 during a load -> next cycle all outputs are 0 and the state is IDLE;
//     no done pulse; rst together with start in IDLE -> start ignored.

Source files
------------

// File: rtl/comp_weight_loader_if.sv
// Bus bundle between the compensation-weight loader, its compensation memory and the CPE columns.
// The loader takes the slave modport; the environment (sequencer, memory, CPEs) takes master.
interface comp_weight_loader_if #(
    parameter int unsigned COLS   = 8,
    parameter int unsigned ADDR_W = 10
);
    logic                 start;
    logic                 abort;
    logic [ADDR_W-1:0]    tile_base;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_rd_addr;
    logic [3*COLS-1:0]    mem_rd_data;
    logic [3*COLS-1:0]    cw_out;
    logic                 cw_valid;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, abort, tile_base, mem_rd_data,
        output mem_rd_en, mem_rd_addr, cw_out, cw_valid, busy, done
    );

    modport master (
        output start, abort, tile_base, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, cw_out, cw_valid, busy, done
    );
endinterface

// File: rtl/comp_weight_loader.sv
// Compensation-weight preload: reads one tile last-row-first from memory and shifts it into
// the CPE columns as a gap-free burst of ROWS valid beats, then pulses done.
module comp_weight_loader #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned ADDR_W = 10
) (
    input logic                 clk,
    input logic                 rst,
    comp_weight_loader_if.slave bus
);
    localparam int unsigned     CntW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CntW-1:0] CntTop = CntW'(ROWS - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rd_vld_q;
    logic              cw_valid_q;
    logic [3*COLS-1:0] cw_q;
    logic              rd_en;

    assign rd_en = (state_q == StFetch);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        if (state_q != StIdle && bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        state_d = StFetch;
                        base_d  = bus.tile_base;
                        cnt_d   = CntTop;
                    end
                end
                StFetch: begin
                    if (cnt_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                // Leave once the last read's data has been registered onto cw_out.
                StDrain: begin
                    if (!rd_vld_q) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            rd_vld_q   <= 1'b0;
            cw_valid_q <= 1'b0;
            cw_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            // Abort discards whatever read data is still in the pipe.
            rd_vld_q   <= rd_en && !bus.abort;
            cw_valid_q <= rd_vld_q && !bus.abort;
            if (rd_vld_q && !bus.abort) begin
                cw_q <= bus.mem_rd_data;
            end
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = base_q + ADDR_W'(cnt_q);
    assign bus.cw_out      = cw_q;
    assign bus.cw_valid    = cw_valid_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
endmodule

// File: tb/tb_comp_weight_loader.sv
// Directed bench for comp_weight_loader (ROWS=4, COLS=2, ADDR_W=10) with a memory model
// and a 4-deep CPE shift-chain model; cycle k of a log is cycle T+k after the start edge T.
module tb_comp_weight_loader;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 2;
    localparam int unsigned ADDR_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    comp_weight_loader_if #(.COLS(COLS), .ADDR_W(ADDR_W)) bus ();

    comp_weight_loader #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0] mem [0:1023];
    logic [5:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_rd_en) rdata_q <= mem[bus.mem_rd_addr];
    end
    assign bus.mem_rd_data = rdata_q;

    logic [5:0] cpe [0:3];
    always @(posedge clk) begin
        if (bus.cw_valid) begin
            cpe[0] <= bus.cw_out;
            cpe[1] <= cpe[0];
            cpe[2] <= cpe[1];
            cpe[3] <= cpe[2];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        log_en   [0:15];
    logic [9:0]  log_addr [0:15];
    logic        log_vld  [0:15];
    logic [5:0]  log_cw   [0:15];
    logic        log_busy [0:15];
    logic        log_done [0:15];

    task automatic launch(input logic [9:0] base);
        bus.tile_base = base;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Log n cycles; mask bit k drives that input during cycle T+k.
    task automatic record(input int n, input logic [31:0] start_m, input logic [31:0] abort_m,
                          input logic [31:0] rst_m);
        for (int k = 1; k <= n; k++) begin
            log_en[k]   = bus.mem_rd_en;
            log_addr[k] = bus.mem_rd_addr;
            log_vld[k]  = bus.cw_valid;
            log_cw[k]   = bus.cw_out;
            log_busy[k] = bus.busy;
            log_done[k] = bus.done;
            bus.start   = start_m[k];
            bus.abort   = abort_m[k];
            rst         = rst_m[k];
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic count_events(input int n, output int beats, output int dones);
        beats = 0;
        dones = 0;
        for (int k = 1; k <= n; k++) begin
            beats += int'(log_vld[k]);
            dones += int'(log_done[k]);
        end
    endtask

    int beats, dones;
    logic [5:0] exp_cw [0:3];
    logic [9:0] exp_a  [0:3];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h100] = 6'o10;
        mem[10'h101] = 6'o32;
        mem[10'h102] = 6'o54;
        mem[10'h103] = 6'o76;
        mem[10'h001] = 6'o21;
        mem[10'h000] = 6'o43;
        mem[10'h3FF] = 6'o65;
        mem[10'h3FE] = 6'o07;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.tile_base = '0;
        repeat (3) @(negedge clk);
        check("reset rd_en", 32'(bus.mem_rd_en), 0);
        check("reset addr", 32'(bus.mem_rd_addr), 0);
        check("reset cw_out", 32'(bus.cw_out), 0);
        check("reset valid/busy/done", {29'd0, bus.cw_valid, bus.busy, bus.done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic tile load, ignored start at T+2, accepted start at T+8.
        exp_cw = '{6'o76, 6'o54, 6'o32, 6'o10};
        launch(10'h100);
        record(10, (32'd1 << 2) | (32'd1 << 8), 0, 0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("A rd_en T+%0d", k), 32'(log_en[k]), 1);
            check($sformatf("A addr T+%0d", k), 32'(log_addr[k]), 32'(10'h103 - 10'(k - 1)));
            check($sformatf("A cw T+%0d", k + 2), {26'd0, log_cw[k + 2]}, {26'd0, exp_cw[k - 1]});
            check($sformatf("A valid T+%0d", k + 2), 32'(log_vld[k + 2]), 1);
        end
        check("A rd_en T+5", 32'(log_en[5]), 0);
        check("A valid T+2", 32'(log_vld[2]), 0);
        check("A valid T+7", 32'(log_vld[7]), 0);
        check("A cw hold T+7", {26'd0, log_cw[7]}, 32'o10);
        check("A done T+7", 32'(log_done[7]), 1);
        check("A busy T+1", 32'(log_busy[1]), 1);
        check("A busy T+7", 32'(log_busy[7]), 1);
        check("A busy T+8", 32'(log_busy[8]), 0);
        count_events(8, beats, dones);
        check("A beat count", 32'(beats), 4);
        check("A done count", 32'(dones), 1);
        check("A restart rd_en T+9", 32'(log_en[9]), 1);
        check("A restart addr T+9", 32'(log_addr[9]), 32'h103);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("A cpe row %0d", r), {26'd0, cpe[r]}, {26'd0, exp_cw[3 - r]});
        end
        repeat (10) @(negedge clk);
        check("A second load idle", 32'(bus.busy), 0);

        // Abort mid-fetch, then a normal load.
        launch(10'h100);
        record(8, 0, 32'd1 << 4, 0);
        check("B rd_en T+4", 32'(log_en[4]), 1);
        check("B rd_en T+5", 32'(log_en[5]), 0);
        check("B valid T+5", 32'(log_vld[5]), 0);
        check("B busy T+5", 32'(log_busy[5]), 0);
        count_events(8, beats, dones);
        check("B done count", 32'(dones), 0);
        launch(10'h100);
        record(8, 0, 0, 0);
        check("B2 addr T+1", 32'(log_addr[1]), 32'h103);
        check("B2 cw T+3", {26'd0, log_cw[3]}, 32'o76);
        check("B2 done T+7", 32'(log_done[7]), 1);

        // Address wrap.
        exp_a  = '{10'h001, 10'h000, 10'h3FF, 10'h3FE};
        exp_cw = '{6'o21, 6'o43, 6'o65, 6'o07};
        launch(10'h3FE);
        record(8, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("C addr T+%0d", k), 32'(log_addr[k]), 32'(exp_a[k - 1]));
            check($sformatf("C cw T+%0d", k + 2), {26'd0, log_cw[k + 2]}, {26'd0, exp_cw[k - 1]});
        end
        check("C done T+7", 32'(log_done[7]), 1);

        // Reset mid-load, then reset together with start in IDLE.
        launch(10'h100);
        record(8, 0, 0, 32'd1 << 5);
        check("D rd_en T+6", 32'(log_en[6]), 0);
        check("D addr T+6", 32'(log_addr[6]), 0);
        check("D cw T+6", {26'd0, log_cw[6]}, 0);
        check("D valid/busy/done T+6", {29'd0, log_vld[6], log_busy[6], log_done[6]}, 0);
        count_events(8, beats, dones);
        check("D done count", 32'(dones), 0);
        bus.tile_base = 10'h100;
        record(4, 32'd1 << 1, 0, 32'd1 << 1);
        check("D rst+start busy T+2", 32'(log_busy[2]), 0);
        check("D rst+start rd_en T+2", 32'(log_en[2]), 0);
        check("D rst+start busy T+4", 32'(log_busy[4]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
